dma_timing_control: RTL
=======================

DMA_TIMING_CONTROL -- requirements
Module: dma_timing_control

Interface
REQ-001 SHALL have parameters: NUM_CH, 4, number of DMA channels; ADDR_W, 16, transfer address width.
REQ-002 SHALL use clock clock and reset reset, where reset is synchronous and active-high.
REQ-003 SHALL have ports (name  direction  width  meaning):
- clock  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- dreq  in  NUM_CH  per-channel DMA request, active-high.
- ch_mask  in  NUM_CH  1 = channel masked, its dreq is ignored.
- ch_type  in  NUM_CH x 2  per-channel transfer type: 00 verify, 01 write (I/O->mem), 10 read (mem->I/O), 11 reserved (treated as verify).
- cur_addr  in  NUM_CH x ADDR_W  current address per channel, from the register block.
- cur_count  in  NUM_CH x 16  current word count per channel.
- hlda  in  1  hold acknowledge from the processor.
- ready  in  1  memory/I/O ready; low inserts wait states.
- hrq  out  1  hold request to the processor.
- aen  out  1  address enable.
- adstb  out  1  upper-address strobe.
- db_addr_hi  out  8  address[15:8], driven onto the data bus during S1.
- addr_lo  out  8  address[7:0].
- dack  out  NUM_CH  DMA acknowledge, one-hot.
- nmemr, nmemw, nior, niow  out  1 each  bus strobes, active-low.
- upd_valid  out  1  one-cycle pulse: the register block steps address/count for upd_ch.
- upd_ch  out  2  channel index for the update.
- tc  out  1  terminal-count pulse.
- neop  out  1  end-of-process, active-low.

Function
REQ-004 SHALL implement a Moore FSM with states SI, S0, S1, S2, S3, SW, S4; all outputs SHALL decode from registered state and the latched channel.
REQ-005 SI: hrq=0; next cycle -> S0 if any dreq & ~ch_mask is set, else stay in SI.
REQ-006 S0: hrq=1. While hlda=0, stay in S0. On hlda=1, latch the highest-priority unmasked active channel (ch0 highest) and its type/address/count, then go to S1. If no channel is requesting at that point, go to SI and drop hrq.
REQ-007 S1: aen=1, adstb=1, db_addr_hi=addr[15:8], addr_lo=addr[7:0]; -> S2.
REQ-008 S2: adstb=0; aen and address held; dack[ch]=1; read strobe low (nmemr for read type, nior for write type, none for verify); -> S3.
REQ-009 S3: write strobe low (nmemw for write type, niow for read type, none for verify); read strobe held low. If ready=1 -> S4, else -> SW.
REQ-010 SW: all S3 outputs held; -> S4 on the first cycle ready=1.
REQ-011 S4: all strobes high; dack held; upd_valid=1; upd_ch=latched channel; if latched count==16'h0000, tc=1 and neop=0; -> SI.
REQ-012 Single-transfer mode only: hrq SHALL drop in SI after every transfer, so the minimum spacing between transfers is one SI cycle.
REQ-013 If hlda falls in S1..SW, the FSM SHALL go to SI next cycle, deassert all strobes, and SHALL NOT pulse upd_valid or tc.
REQ-014 A dreq change after the channel is latched SHALL NOT affect the transfer in progress.
REQ-015 A reserved ch_type (11) SHALL behave exactly like verify.

Reset
REQ-016 While reset=1, the FSM SHALL enter SI with hrq, aen, adstb, upd_valid, tc = 0; all strobes, neop = 1; dack = 0; address outputs and latched channel = 0; this applies from any state, including mid-transfer.

Configuration
REQ-017 With DMA_EXT_WRITE_EN defined, the write strobe SHALL assert from S2 (extended write). Without the macro, the write strobe SHALL assert from S3.

Structure
REQ-018 Package dma_pkg SHALL hold: the state enum (one-hot), the transfer-type enum, and the NUM_CH/ADDR_W defaults.
REQ-019 The fixed-priority arbiter SHALL be a sub-module, dma_priority_enc (NUM_CH-bit request in, index + valid out).

Verification
REQ-020 ch1 read, dreq=0010, addr=16'h3456, count=5, hlda raised 2 cycles after hrq, ready=1 -> S1 drives db_addr_hi=34 and addr_lo=56; nmemr low in S2-S3; niow low in S3; one upd_valid with upd_ch=1; tc=0.
REQ-021 dreq=1010 at hlda -> ch1 served first, dack=0010; ch3 served after the following SI.
REQ-022 ch0 write, count=0, ready low for 3 cycles in S3 -> 3 SW cycles; nior/nmemw held low; tc=1 and neop=0 for exactly 1 cycle in S4.
REQ-023 Verify type -> no strobe toggles; dack and upd_valid still occur.
REQ-024 hlda dropped in S2, and separately reset asserted in SW -> return to SI with no upd_valid and all outputs at reset values.
REQ-025 Build with DMA_EXT_WRITE_EN -> nmemw low starting in S2 for a write transfer.

Source files
------------

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types and defaults for the DMA timing control block
//
// Contents:
//   NUM_CH_DEF / ADDR_W_DEF  default channel count and transfer address width
//   dma_state_e              one-hot timing state (SI, S0, S1, S2, S3, SW, S4)
//   xfer_type_e              per-channel transfer type encoding

package dma_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int ADDR_W_DEF = 16;

    typedef enum logic [6:0] {
        ST_SI = 7'b000_0001,
        ST_S0 = 7'b000_0010,
        ST_S1 = 7'b000_0100,
        ST_S2 = 7'b000_1000,
        ST_S3 = 7'b001_0000,
        ST_SW = 7'b010_0000,
        ST_S4 = 7'b100_0000
    } dma_state_e;

    // Reserved (11) deliberately decodes as neither read nor write, so it
    // behaves as a verify cycle everywhere the type is used.
    typedef enum logic [1:0] {
        XT_VERIFY = 2'b00,
        XT_WRITE  = 2'b01,
        XT_READ   = 2'b10,
        XT_RSVD   = 2'b11
    } xfer_type_e;

endpackage

// File: rtl/dma_priority_enc.sv
// rtl/dma_priority_enc.sv - fixed-priority request encoder, bit 0 highest
//
// Ports:
//   req    in   NUM_CH  qualified request vector
//   idx    out  IDX_W   index of the lowest-numbered set request
//   valid  out  1       at least one request is set

module dma_priority_enc #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = 2
) (
    input  logic [NUM_CH-1:0] req,
    output logic [IDX_W-1:0]  idx,
    output logic              valid
);

    // Scan from the top down so the lowest set bit is the last to win.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_timing_control.sv
// rtl/dma_timing_control.sv - single-transfer DMA bus timing state machine
//
// Build option: DMA_EXT_WRITE_EN - when defined the write strobe starts in S2
// (extended write); otherwise it starts in S3.
//
// Ports:
//   clock, reset               system clock, synchronous active-high reset
//   dreq, ch_mask              per-channel request and mask
//   ch_type                    per-channel transfer type (dma_pkg::xfer_type_e)
//   cur_addr, cur_count        per-channel address / word count from registers
//   hlda, ready                hold acknowledge, bus ready (low = wait state)
//   hrq, aen, adstb            hold request, address enable, upper-address strobe
//   db_addr_hi, addr_lo        address[15:8] on the data bus in S1, address[7:0]
//   dack                       one-hot acknowledge of the serviced channel
//   nmemr, nmemw, nior, niow   active-low bus strobes
//   upd_valid, upd_ch          one-cycle address/count step request and channel
//   tc, neop                   terminal-count pulse and active-low end of process

module dma_timing_control
    import dma_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_CH-1:0]              dreq,
    input  logic [NUM_CH-1:0]              ch_mask,
    input  logic [NUM_CH-1:0][1:0]         ch_type,
    input  logic [NUM_CH-1:0][ADDR_W-1:0]  cur_addr,
    input  logic [NUM_CH-1:0][15:0]        cur_count,
    input  logic                           hlda,
    input  logic                           ready,
    output logic                           hrq,
    output logic                           aen,
    output logic                           adstb,
    output logic [7:0]                     db_addr_hi,
    output logic [7:0]                     addr_lo,
    output logic [NUM_CH-1:0]              dack,
    output logic                           nmemr,
    output logic                           nmemw,
    output logic                           nior,
    output logic                           niow,
    output logic                           upd_valid,
    output logic [1:0]                     upd_ch,
    output logic                           tc,
    output logic                           neop
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    dma_state_e          state;
    dma_state_e          state_nxt;
    logic [CH_W-1:0]     lat_ch;
    xfer_type_e          lat_type;
    logic [ADDR_W-1:0]   lat_addr;
    logic [15:0]         lat_count;

    logic [NUM_CH-1:0]   req_q;
    logic [CH_W-1:0]     req_idx;
    logic                req_valid;

    assign req_q = dreq & ~ch_mask;

    dma_priority_enc #(
        .NUM_CH (NUM_CH),
        .IDX_W  (CH_W)
    ) u_prio (
        .req    (req_q),
        .idx    (req_idx),
        .valid  (req_valid)
    );

    // Channel parameters are captured once at grant so later dreq or
    // register changes cannot disturb the transfer in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_SI;
            lat_ch    <= '0;
            lat_type  <= XT_VERIFY;
            lat_addr  <= '0;
            lat_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_S0 && hlda && req_valid) begin
                lat_ch    <= req_idx;
                lat_type  <= xfer_type_e'(ch_type[req_idx]);
                lat_addr  <= cur_addr[req_idx];
                lat_count <= cur_count[req_idx];
            end
        end
    end

    // Losing hlda anywhere between S1 and SW abandons the cycle before S4,
    // so neither the register update nor terminal count is signalled.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_SI: state_nxt = req_valid ? ST_S0 : ST_SI;
            ST_S0: begin
                if (hlda) begin
                    state_nxt = req_valid ? ST_S1 : ST_SI;
                end
            end
            ST_S1: state_nxt = hlda ? ST_S2 : ST_SI;
            ST_S2: state_nxt = hlda ? ST_S3 : ST_SI;
            ST_S3: begin
                if (!hlda) begin
                    state_nxt = ST_SI;
                end else begin
                    state_nxt = ready ? ST_S4 : ST_SW;
                end
            end
            ST_SW: begin
                if (!hlda) begin
                    state_nxt = ST_SI;
                end else if (ready) begin
                    state_nxt = ST_S4;
                end
            end
            ST_S4:   state_nxt = ST_SI;
            default: state_nxt = ST_SI;
        endcase
    end

    logic [15:0] addr_ext;
    logic        addr_phase;
    logic        dack_phase;
    logic        rd_phase;
    logic        wr_phase;
    logic        is_read;
    logic        is_write;

    assign addr_ext   = 16'(lat_addr);
    assign addr_phase = (state == ST_S1) || (state == ST_S2) || (state == ST_S3) ||
                        (state == ST_SW) || (state == ST_S4);
    assign dack_phase = (state == ST_S2) || (state == ST_S3) ||
                        (state == ST_SW) || (state == ST_S4);
    assign rd_phase   = (state == ST_S2) || (state == ST_S3) || (state == ST_SW);
`ifdef DMA_EXT_WRITE_EN
    assign wr_phase   = (state == ST_S2) || (state == ST_S3) || (state == ST_SW);
`else
    assign wr_phase   = (state == ST_S3) || (state == ST_SW);
`endif
    assign is_read    = (lat_type == XT_READ);
    assign is_write   = (lat_type == XT_WRITE);

    always_comb begin
        hrq        = (state != ST_SI);
        aen        = addr_phase;
        adstb      = (state == ST_S1);
        db_addr_hi = (state == ST_S1) ? addr_ext[15:8] : 8'h00;
        addr_lo    = addr_phase ? addr_ext[7:0] : 8'h00;
        dack       = dack_phase ? (NUM_CH'(1) << lat_ch) : '0;
        // Read type moves memory to I/O: memory read then I/O write.
        nmemr      = !(rd_phase && is_read);
        niow       = !(wr_phase && is_read);
        nior       = !(rd_phase && is_write);
        nmemw      = !(wr_phase && is_write);
        upd_valid  = (state == ST_S4);
        upd_ch     = (state == ST_S4) ? 2'(lat_ch) : 2'd0;
        tc         = (state == ST_S4) && (lat_count == 16'h0000);
        neop       = !tc;
    end

endmodule
